// File: rtl/mips16_pkg.sv
// Shared constants and helpers for the 16-bit MIPS datapath: widths,
// ALU opcode encodings and immediate sign extension.
package mips16_pkg;

  localparam int WIDTH   = 16;
  localparam int RADDR_W = 3;
  localparam int IMM_W   = 6;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;

  function automatic logic [WIDTH-1:0] sign_extend(input logic [IMM_W-1:0] imm);
    sign_extend = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_forward_mux.sv
// Resolves one source operand against the EX, MEM and WB writeback
// candidates, in that priority order; register 0 always reads as zero.
module forward_mux
  import mips16_pkg::*;
(
  input  logic [RADDR_W-1:0] i_src,
  input  logic               i_ex_en,
  input  logic [RADDR_W-1:0] i_ex_rd,
  input  logic [WIDTH-1:0]   i_ex_data,
  input  logic               i_mem_en,
  input  logic [RADDR_W-1:0] i_mem_rd,
  input  logic [WIDTH-1:0]   i_mem_data,
  input  logic               i_wb_en,
  input  logic [RADDR_W-1:0] i_wb_rd,
  input  logic [WIDTH-1:0]   i_wb_data,
  input  logic [WIDTH-1:0]   i_rf_data,
  output logic [WIDTH-1:0]   o_operand
);

  logic w_srcNonZero;
  logic w_exHit;
  logic w_memHit;
  logic w_wbHit;

  assign w_srcNonZero = (i_src != '0);
  assign w_exHit      = w_srcNonZero & i_ex_en  & (i_ex_rd  == i_src);
  assign w_memHit     = w_srcNonZero & i_mem_en & (i_mem_rd == i_src);
  assign w_wbHit      = w_srcNonZero & i_wb_en  & (i_wb_rd  == i_src);

  always_comb begin
    o_operand = i_rf_data;
    if (!w_srcNonZero) begin
      o_operand = '0;
    end else if (w_exHit) begin
      o_operand = i_ex_data;
    end else if (w_memHit) begin
      o_operand = i_mem_data;
    end else if (w_wbHit) begin
      o_operand = i_wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards operands, sign-extends immediates and
// inserts a single bubble on load-use, honouring downstream stall and flush.
module id_ex_stage
  import mips16_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_opcode,
  input  logic [RADDR_W-1:0] in_rs,
  input  logic [RADDR_W-1:0] in_rt,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [WIDTH-1:0]   in_rs_data,
  input  logic [WIDTH-1:0]   in_rt_data,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic               in_use_imm,
  input  logic               in_reg_write,
  input  logic               in_is_load,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [WIDTH-1:0]   mem_data,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]   wb_data,
  input  logic               ex_stall,
  input  logic               flush,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [3:0]         opcode,
  output logic               out_valid,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write,
  output logic               out_is_load,
  output logic               hazard
);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_opcode;
  logic               r_valid;
  logic [RADDR_W-1:0] r_rd;
  logic               r_regWrite;
  logic               r_isLoad;

  logic               w_exFwdEn;
  logic               w_hazard;
  logic [WIDTH-1:0]   w_rsOperand;
  logic [WIDTH-1:0]   w_rtOperand;
  logic [WIDTH-1:0]   w_bOperand;

  // A held load cannot forward from EX: its alu_result is the address, not the data.
  assign w_exFwdEn = r_valid & r_regWrite & ~r_isLoad;

  assign w_hazard = in_valid & r_valid & r_isLoad & (r_rd != '0) &
                    ((r_rd == in_rs) | (~in_use_imm & (r_rd == in_rt)));

  assign hazard   = w_hazard;
  assign in_ready = ~ex_stall & ~w_hazard;

  forward_mux u_fwdRs (
    .i_src      (in_rs),
    .i_ex_en    (w_exFwdEn),
    .i_ex_rd    (r_rd),
    .i_ex_data  (alu_result),
    .i_mem_en   (mem_reg_write),
    .i_mem_rd   (mem_rd),
    .i_mem_data (mem_data),
    .i_wb_en    (wb_reg_write),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .i_rf_data  (in_rs_data),
    .o_operand  (w_rsOperand)
  );

  forward_mux u_fwdRt (
    .i_src      (in_rt),
    .i_ex_en    (w_exFwdEn),
    .i_ex_rd    (r_rd),
    .i_ex_data  (alu_result),
    .i_mem_en   (mem_reg_write),
    .i_mem_rd   (mem_rd),
    .i_mem_data (mem_data),
    .i_wb_en    (wb_reg_write),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .i_rf_data  (in_rt_data),
    .o_operand  (w_rtOperand)
  );

  assign w_bOperand = in_use_imm ? sign_extend(in_imm) : w_rtOperand;

  // Bubbles and invalid slots clear only the tags; operand registers keep their last value.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_opcode   <= 4'b0000;
      r_valid    <= 1'b0;
      r_rd       <= '0;
      r_regWrite <= 1'b0;
      r_isLoad   <= 1'b0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_isLoad   <= 1'b0;
    end else if (!ex_stall) begin
      if (w_hazard) begin
        r_valid    <= 1'b0;
        r_regWrite <= 1'b0;
        r_isLoad   <= 1'b0;
      end else begin
        r_valid    <= in_valid;
        r_regWrite <= in_valid & in_reg_write;
        r_isLoad   <= in_valid & in_is_load;
        if (in_valid) begin
          r_a      <= w_rsOperand;
          r_b      <= w_bOperand;
          r_opcode <= in_opcode;
          r_rd     <= in_rd;
        end
      end
    end
  end

  assign A             = r_a;
  assign B             = r_b;
  assign opcode        = r_opcode;
  assign out_valid     = r_valid;
  assign out_rd        = r_rd;
  assign out_reg_write = r_regWrite;
  assign out_is_load   = r_isLoad;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, forwarding priority,
// immediates, load-use bubble, stall/flush and register-0 handling.
module tb_id_ex_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [2:0]  in_rs;
  logic [2:0]  in_rt;
  logic [2:0]  in_rd;
  logic [15:0] in_rs_data;
  logic [15:0] in_rt_data;
  logic [5:0]  in_imm;
  logic        in_use_imm;
  logic        in_reg_write;
  logic        in_is_load;
  logic [15:0] alu_result;
  logic        mem_reg_write;
  logic [2:0]  mem_rd;
  logic [15:0] mem_data;
  logic        wb_reg_write;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        ex_stall;
  logic        flush;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  opcode;
  logic        out_valid;
  logic [2:0]  out_rd;
  logic        out_reg_write;
  logic        out_is_load;
  logic        hazard;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_rs         (in_rs),
    .in_rt         (in_rt),
    .in_rd         (in_rd),
    .in_rs_data    (in_rs_data),
    .in_rt_data    (in_rt_data),
    .in_imm        (in_imm),
    .in_use_imm    (in_use_imm),
    .in_reg_write  (in_reg_write),
    .in_is_load    (in_is_load),
    .alu_result    (alu_result),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .ex_stall      (ex_stall),
    .flush         (flush),
    .A             (A),
    .B             (B),
    .opcode        (opcode),
    .out_valid     (out_valid),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .out_is_load   (out_is_load),
    .hazard        (hazard)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] op,
                               input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                               input logic [15:0] rsData, input logic [15:0] rtData,
                               input logic [5:0] imm, input logic useImm,
                               input logic regWrite, input logic isLoad);
    in_valid     = valid;
    in_opcode    = op;
    in_rs        = rs;
    in_rt        = rt;
    in_rd        = rd;
    in_rs_data   = rsData;
    in_rt_data   = rtData;
    in_imm       = imm;
    in_use_imm   = useImm;
    in_reg_write = regWrite;
    in_is_load   = isLoad;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    alu_result = 16'h0; mem_reg_write = 1'b0; mem_rd = 3'd0; mem_data = 16'h0;
    wb_reg_write = 1'b0; wb_rd = 3'd0; wb_data = 16'h0;
    applyStimulus(1'b1, 4'b0000, 3'd1, 3'd2, 3'd5, 16'h0003, 16'h0004, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("reset_A", A, 16'h0000);
    checkOutput("reset_B", B, 16'h0000);
    checkOutput("reset_opcode", {12'h0, opcode}, 16'h0000);
    checkOutput("reset_out_valid", {15'h0, out_valid}, 16'h0000);
    checkOutput("reset_out_rd", {13'h0, out_rd}, 16'h0000);
    checkOutput("reset_out_reg_write", {15'h0, out_reg_write}, 16'h0000);
    checkOutput("reset_out_is_load", {15'h0, out_is_load}, 16'h0000);

    // ADD r5 <- r1, r2 captured one edge after release
    reset_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", {15'h0, in_ready}, 16'h0001);
    tick();
    checkOutput("add_A", A, 16'h0003);
    checkOutput("add_B", B, 16'h0004);
    checkOutput("add_opcode", {12'h0, opcode}, 16'h0000);
    checkOutput("add_out_valid", {15'h0, out_valid}, 16'h0001);
    checkOutput("add_out_rd", {13'h0, out_rd}, 16'h0005);

    // ADDI r4 <- r6 + (-2)
    applyStimulus(1'b1, 4'b0010, 3'd6, 3'd0, 3'd4, 16'h0010, 16'h0000, 6'b111110, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("addi_A", A, 16'h0010);
    checkOutput("addi_B", B, 16'hFFFE);
    checkOutput("addi_opcode", {12'h0, opcode}, 16'h0002);

    // ADD r3 <- r1, r2 then SUB using r3: EX beats MEM
    applyStimulus(1'b1, 4'b0000, 3'd1, 3'd2, 3'd3, 16'h0001, 16'h0002, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("add3_A", A, 16'h0001);
    applyStimulus(1'b1, 4'b0001, 3'd3, 3'd1, 3'd6, 16'h9999, 16'h0007, 6'd0, 1'b0, 1'b1, 1'b0);
    alu_result = 16'h1234; mem_reg_write = 1'b1; mem_rd = 3'd3; mem_data = 16'h5555;
    tick();
    checkOutput("sub_fwd_ex_A", A, 16'h1234);
    checkOutput("sub_B", B, 16'h0007);
    checkOutput("sub_opcode", {12'h0, opcode}, 16'h0001);
    mem_reg_write = 1'b0; mem_rd = 3'd0; mem_data = 16'h0; alu_result = 16'h0;

    // Load r2, then ADD using r2 stalls one cycle and takes MEM data
    applyStimulus(1'b1, 4'b0000, 3'd7, 3'd0, 3'd2, 16'h0020, 16'h0000, 6'd0, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("load_is_load", {15'h0, out_is_load}, 16'h0001);
    checkOutput("load_A", A, 16'h0020);
    applyStimulus(1'b1, 4'b0000, 3'd2, 3'd1, 3'd7, 16'h1111, 16'h0005, 6'd0, 1'b0, 1'b1, 1'b0);
    alu_result = 16'hDEAD;
    #1;
    checkOutput("loaduse_hazard", {15'h0, hazard}, 16'h0001);
    checkOutput("loaduse_in_ready", {15'h0, in_ready}, 16'h0000);
    tick();
    checkOutput("bubble_out_valid", {15'h0, out_valid}, 16'h0000);
    checkOutput("bubble_reg_write", {15'h0, out_reg_write}, 16'h0000);
    checkOutput("bubble_is_load", {15'h0, out_is_load}, 16'h0000);
    checkOutput("bubble_A_held", A, 16'h0020);
    mem_reg_write = 1'b1; mem_rd = 3'd2; mem_data = 16'h00AA;
    #1;
    checkOutput("after_bubble_hazard", {15'h0, hazard}, 16'h0000);
    checkOutput("after_bubble_in_ready", {15'h0, in_ready}, 16'h0001);
    tick();
    checkOutput("loaduse_fwd_mem_A", A, 16'h00AA);
    checkOutput("loaduse_B", B, 16'h0005);
    checkOutput("loaduse_out_valid", {15'h0, out_valid}, 16'h0001);
    checkOutput("loaduse_out_rd", {13'h0, out_rd}, 16'h0007);
    mem_reg_write = 1'b0; mem_rd = 3'd0; mem_data = 16'h0; alu_result = 16'h0;

    // Three stalled cycles freeze everything, then flush with stall clears tags
    applyStimulus(1'b1, 4'b0001, 3'd1, 3'd1, 3'd1, 16'h0100, 16'h0100, 6'd0, 1'b0, 1'b1, 1'b0);
    ex_stall = 1'b1;
    #1;
    checkOutput("stall_in_ready", {15'h0, in_ready}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_A_frozen", A, 16'h00AA);
      checkOutput("stall_opcode_frozen", {12'h0, opcode}, 16'h0000);
      checkOutput("stall_out_valid", {15'h0, out_valid}, 16'h0001);
    end
    flush = 1'b1;
    tick();
    checkOutput("flush_out_valid", {15'h0, out_valid}, 16'h0000);
    checkOutput("flush_reg_write", {15'h0, out_reg_write}, 16'h0000);
    flush = 1'b0; ex_stall = 1'b0;

    // rs=0 never forwards even with a WB write to r0
    applyStimulus(1'b1, 4'b0000, 3'd0, 3'd0, 3'd0, 16'h7777, 16'h3333, 6'd0, 1'b0, 1'b0, 1'b0);
    wb_reg_write = 1'b1; wb_rd = 3'd0; wb_data = 16'hFFFF;
    tick();
    checkOutput("r0_A", A, 16'h0000);
    checkOutput("r0_B", B, 16'h0000);

    // WB forwarding on rt, register file on rs
    applyStimulus(1'b1, 4'b0011, 3'd4, 3'd5, 3'd1, 16'h0002, 16'h0001, 6'd0, 1'b0, 1'b1, 1'b0);
    wb_reg_write = 1'b1; wb_rd = 3'd5; wb_data = 16'hBEEF;
    tick();
    checkOutput("wb_fwd_A", A, 16'h0002);
    checkOutput("wb_fwd_B", B, 16'hBEEF);
    checkOutput("wb_opcode", {12'h0, opcode}, 16'h0003);
    wb_reg_write = 1'b0; wb_rd = 3'd0; wb_data = 16'h0;

    // Invalid slot clears tags but holds operands
    applyStimulus(1'b0, 4'b0111, 3'd1, 3'd2, 3'd3, 16'h4444, 16'h4444, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("invalid_out_valid", {15'h0, out_valid}, 16'h0000);
    checkOutput("invalid_A_held", A, 16'h0002);
    checkOutput("invalid_opcode_held", {12'h0, opcode}, 16'h0003);

    // Reset during stall drops the held instruction
    applyStimulus(1'b1, 4'b0100, 3'd1, 3'd2, 3'd3, 16'h0009, 16'h000A, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();
    ex_stall = 1'b1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; ex_stall = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("reset_stall_in_ready", {15'h0, in_ready}, 16'h0001);
    checkOutput("reset_stall_out_valid", {15'h0, out_valid}, 16'h0000);
    checkOutput("reset_stall_A", A, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
